srff_driver: RTL
================

# srff_driver

Clocked command-side driver for the level-sensitive SR flip-flop (SRFF) bistable. It accepts requested output levels over a valid/ready handshake and converts each one into a single clean set or reset pulse of fixed width followed by a guard interval. It never asserts set and reset together, and it skips redundant pulses. It also reads the flop's q output back through a synchronizer and flags any mismatch. It sits between synchronous control logic and any SRFF instance.

## Interface
- PULSE_W, 2: s/r pulse width in clk cycles; must be >= 1.
- GAP_W, 4: guard cycles with s=r=0 after each pulse; must be >= 3 to cover the feedback synchronizer.
- INIT_Q, 0: predicted latch level after reset.

- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_level  in  1  requested q level.
- req_force  in  1  pulse even if the predicted level already equals req_level.
- req_ready  out  1  request can be accepted this cycle.
- s  out  1  set drive to the SRFF.
- r  out  1  reset drive to the SRFF.
- q_fb  in  1  SRFF q output; asynchronous to clk.
- q_pred  out  1  predicted latch level.
- busy  out  1  a pulse or guard interval is in progress.
- err  out  1  sticky feedback-mismatch flag.
- err_clr  in  1  synchronous clear of err.

## Operation
- **States:** IDLE, SET, RST, GAP.
- **Handshake:** a request is accepted on any edge where req_valid=1 and req_ready=1. req_ready=1 only in IDLE.
- **IDLE, accepted request:**
  - If req_level != q_pred, or req_force=1: go to SET when req_level=1, or to RST when req_level=0. Load the counter with PULSE_W-1 and set q_pred := req_level.
  - Otherwise the request completes as a no-op: stay in IDLE, no pulse, q_pred unchanged.
- **SET / RST:** s=1 (SET) or r=1 (RST). Decrement the counter. When it reaches 0, go to GAP and load GAP_W-1.
- **GAP:** s=r=0. Decrement the counter. When it reaches 0, compare the synchronized q_fb with q_pred. On mismatch, set err. Then go to IDLE.
- **Outputs:**
  - s and r are registered, decoded from state only. s and r are never 1 in the same cycle, including across state transitions.
  - busy=1 in SET, RST and GAP.
- **Feedback:** q_fb passes through a 2-flop synchronizer. Its value is used only at the GAP exit compare.
- **err:**
  - Sticky until err_clr=1.
  - When err_clr and a new mismatch occur on the same edge, the mismatch wins and err stays 1.
  - err does not block further requests.
- **Counter:** width $clog2(max(PULSE_W,GAP_W)). It saturates at 0 and never wraps.

## Timing
- **Reset values:** state=IDLE, s=0, r=0, q_pred=INIT_Q, busy=0, err=0, req_ready=1, synchronizer flops=INIT_Q.
- **Reset asserted mid-pulse:** s and r drop to 0 asynchronously. The request in progress is lost and is not retried.
- **Pulse timing:** with the request accepted at edge 0:
  - s or r is high during cycles 1..PULSE_W.
  - GAP spans cycles PULSE_W+1..PULSE_W+GAP_W.
  - req_ready returns to 1 in cycle PULSE_W+GAP_W+1.
  - Total occupancy is PULSE_W+GAP_W cycles.
- **No-op request:** accepted in one cycle. req_ready stays 1, so back-to-back no-ops sustain one per cycle.
- **Request while busy:** req_valid held during busy is not accepted. It is taken on the first IDLE edge, with the level sampled on that edge.
- **Minimum spacing:** two real pulses are separated by at least GAP_W zero cycles on both s and r.

## Structure
- Package srff_pkg holds:
  - the state enum typedef (IDLE, SET, RST, GAP);
  - default PULSE_W and GAP_W constants;
  - a minimum-GAP_W constant (3) for parameter checking via elaboration-time assertion.
- Sub-module sync2 is the 2-flop synchronizer for q_fb, with async active-low reset to a parameterized value.
- The top level is the FSM, the counter and the err register.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles, INIT_Q=0 → s=0, r=0, q_pred=0, req_ready=1, err=0, busy=0.
- **Set request:** req_level=1 accepted at edge 0, with a behavioural SRFF model on s/r/q_fb → s=1 in cycles 1–2, r=0 throughout, req_ready=1 in cycle 7, q_pred=1, err=0.
- **Redundant and forced requests:** at q_pred=1, req_level=1 with force=0 → no pulse, req_ready stays 1. Then force=1 → s pulse of 2 cycles.
- **Alternating requests:** req_valid held with levels 1,0,1 → one s, r, s pulse each. s&r never 1, and at least 4 zero cycles between pulses.
- **Feedback mismatch:** q_fb tied to 0, request level 1 → err=1 at cycle 7 and sticky. err_clr=1 for one cycle → err=0.
- **Reset mid-pulse:** rst_n=0 during cycle 1 of a SET → s falls immediately. After release, state=IDLE and q_pred=INIT_Q.

Source files
------------

// File: rtl/srff_pkg.sv
// Shared types and constants for the SR flip-flop command driver.
package srff_pkg;

    // Controller states: idle, set pulse, reset pulse, guard interval.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SET  = 2'd1,
        ST_RST  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int unsigned PULSE_W_DEF = 2;
    localparam int unsigned GAP_W_DEF   = 4;

    // The guard must outlast the two-flop feedback synchronizer plus one compare edge.
    localparam int unsigned MIN_GAP_W   = 3;

    // Larger of two widths; used to size the shared pulse/guard counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/srff_driver_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module srff_driver_sync2 #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; both reset to the expected idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/srff_driver.sv
// Command-side driver for a level-sensitive SR flip-flop: converts level
// requests into single fixed-width set/reset pulses with a guard interval,
// and checks the flop's readback at the end of each guard.
module srff_driver
    import srff_pkg::*;
#(
    parameter int unsigned PULSE_W = PULSE_W_DEF,
    parameter int unsigned GAP_W   = GAP_W_DEF,
    parameter bit          INIT_Q  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_level,
    input  logic req_force,
    output logic req_ready,
    output logic s,
    output logic r,
    input  logic q_fb,
    output logic q_pred,
    output logic busy,
    output logic err,
    input  logic err_clr
);

    localparam int unsigned CNT_MAX = max_u(PULSE_W, GAP_W);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Reject parameter sets that would break pulse shape or feedback timing.
    if (PULSE_W < 1) begin : g_pulse_w_chk
        $error("srff_driver: PULSE_W must be >= 1");
    end
    if (GAP_W < MIN_GAP_W) begin : g_gap_w_chk
        $error("srff_driver: GAP_W must be >= MIN_GAP_W");
    end

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               q_sync;
    logic               accept_c;
    logic               pulse_c;
    logic               cnt_zero_c;
    logic               gap_exit_c;
    logic               mismatch_c;

    // Feedback from the flop is asynchronous; bring it into the clk domain.
    srff_driver_sync2 #(
        .RST_VAL (INIT_Q)
    ) u_sync_q (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (q_fb),
        .q     (q_sync)
    );

    // Request decode: a pulse is needed on a level change or when forced.
    always_comb begin
        accept_c   = req_valid & req_ready;
        pulse_c    = (req_level != q_pred) | req_force;
        cnt_zero_c = (cnt == '0);
        gap_exit_c = (state == ST_GAP) & cnt_zero_c;
        mismatch_c = gap_exit_c & (q_sync != q_pred);
    end

    // Controller: state, shared counter and all registered drive outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            s         <= 1'b0;
            r         <= 1'b0;
            q_pred    <= INIT_Q;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_c && pulse_c) begin
                        state     <= req_level ? ST_SET : ST_RST;
                        cnt       <= CNT_W'(PULSE_W - 1);
                        q_pred    <= req_level;
                        s         <= req_level;
                        r         <= ~req_level;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end
                ST_SET, ST_RST: begin
                    if (cnt_zero_c) begin
                        state <= ST_GAP;
                        cnt   <= CNT_W'(GAP_W - 1);
                        s     <= 1'b0;
                        r     <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_zero_c) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    s         <= 1'b0;
                    r         <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Sticky mismatch flag; a new mismatch takes priority over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (mismatch_c) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule
